// File: rtl/approx_div_16bit_if.sv
// rtl/approx_div_16bit_if.sv - start/done handshake bundle for the approximate divider
interface approx_div_16bit_if;
  logic        start;
  logic [15:0] x1;
  logic [15:0] x2;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        div_by_zero;

  modport master (
    output start, x1, x2,
    input  busy, done, out, div_by_zero
  );

  modport slave (
    input  start, x1, x2,
    output busy, done, out, div_by_zero
  );
endinterface

// File: rtl/approx_div_16bit.sv
// rtl/approx_div_16bit.sv - sequential approximate unsigned divider
// Normalise both operands, divide their top bytes, then rescale by the shift difference.
module approx_div_16bit (
  input  logic              clk,
  input  logic              rst,
  approx_div_16bit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORM  = 3'd1,
    DIV   = 3'd2,
    SCALE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] r1;
  logic [15:0] r2;
  logic [3:0]  k1;
  logic [3:0]  k2;
  logic [7:0]  b8;
  logic [8:0]  rem;
  logic [15:0] q;
  logic [4:0]  step;
  logic [4:0]  s;
  logic        dir_left;
  logic [15:0] out_q;
  logic        dbz_q;

  logic        busy_c;
  logic        done_c;
  logic        zero_op;

  logic [8:0]  rem_sh;
  logic [15:0] q_sh;
  logic [8:0]  rem_nx;
  logic [15:0] q_nx;
  logic [5:0]  d;
  logic [4:0]  d_mag;

  assign zero_op = (bus.x2 == 16'd0) || (bus.x1 == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          state_nxt = zero_op ? DONE : NORM;
        end
      end
      NORM: begin
        if (r1[15] && r2[15]) begin
          state_nxt = DIV;
        end
      end
      DIV: begin
        if (step == 5'd15) begin
          state_nxt = SCALE;
        end
      end
      SCALE: begin
        if (s == 5'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One restoring step: shift {rem,q} left, subtract divisor when it fits.
  always_comb begin
    rem_sh = {rem[7:0], q[15]};
    q_sh   = {q[14:0], 1'b0};
    rem_nx = rem_sh;
    q_nx   = q_sh;
    if (rem_sh >= {1'b0, b8}) begin
      rem_nx = rem_sh - {1'b0, b8};
      q_nx   = q_sh | 16'd1;
    end
  end

  // Exponent of the result relative to Q: out ~= Q * 2^(k2 - k1 - 8).
  always_comb begin
    d     = {2'b00, k2} - {2'b00, k1} - 6'd8;
    d_mag = d[5] ? (5'd0 - d[4:0]) : d[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1       <= 16'd0;
      r2       <= 16'd0;
      k1       <= 4'd0;
      k2       <= 4'd0;
      b8       <= 8'd0;
      rem      <= 9'd0;
      q        <= 16'd0;
      step     <= 5'd0;
      s        <= 5'd0;
      dir_left <= 1'b0;
      out_q    <= 16'd0;
      dbz_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.x2 == 16'd0) begin
              out_q <= 16'hFFFF;
              dbz_q <= 1'b1;
            end else if (bus.x1 == 16'd0) begin
              out_q <= 16'd0;
              dbz_q <= 1'b0;
            end else begin
              r1    <= bus.x1;
              r2    <= bus.x2;
              k1    <= 4'd0;
              k2    <= 4'd0;
              step  <= 5'd0;
              s     <= 5'd0;
              dbz_q <= 1'b0;
            end
          end
        end
        NORM: begin
          if (r1[15] && r2[15]) begin
            q    <= {r1[15:8], 8'h00};
            b8   <= r2[15:8];
            rem  <= 9'd0;
            step <= 5'd0;
          end else begin
            if (!r1[15]) begin
              r1 <= r1 << 1;
              k1 <= k1 + 4'd1;
            end
            if (!r2[15]) begin
              r2 <= r2 << 1;
              k2 <= k2 + 4'd1;
            end
          end
        end
        DIV: begin
          rem  <= rem_nx;
          q    <= q_nx;
          step <= step + 5'd1;
          if (step == 5'd15) begin
            s        <= d_mag;
            dir_left <= ~d[5];
          end
        end
        SCALE: begin
          if (s != 5'd0) begin
            q <= dir_left ? (q << 1) : (q >> 1);
            s <= s - 5'd1;
          end else begin
            out_q <= q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.out         = out_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_approx_div_16bit.sv
// tb/tb_approx_div_16bit.sv - self-checking bench for approx_div_16bit
module tb_approx_div_16bit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  approx_div_16bit_if bus ();

  approx_div_16bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clz16(input logic [15:0] v);
    int n = 16;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) n = 15 - i;
    end
    return n;
  endfunction

  // Arithmetic model: top bytes of the normalised operands, integer quotient, power-of-two rescale.
  task automatic ref_model(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] o, output logic dz, output int lat);
    int k1, k2, a8, b8, qq, d, av, bv;
    dz = 1'b0;
    if (b == 16'd0) begin
      o = 16'hFFFF; dz = 1'b1; lat = 1;
    end else if (a == 16'd0) begin
      o = 16'd0; lat = 1;
    end else begin
      av = int'(a); bv = int'(b);
      k1 = clz16(a); k2 = clz16(b);
      a8 = (av << k1) >> 8;
      b8 = (bv << k2) >> 8;
      qq = (a8 * 256) / b8;
      d  = k2 - k1 - 8;
      if (d >= 0) o = 16'(qq << d);
      else        o = 16'(qq >> (-d));
      lat = ((k1 > k2) ? k1 : k2) + ((d < 0) ? -d : d) + 19;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after done.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eo, input logic edz, input int elat, input int inject_at);
    int edges;
    bit seen;
    edges = 0;
    seen  = 1'b0;
    bus.start = 1'b1;
    bus.x1    = a;
    bus.x2    = b;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(posedge clk);
      edges++;
      #1;
      bus.start = (inject_at != 0 && edges == inject_at);
      bus.x1    = 16'($urandom);
      bus.x2    = 16'($urandom);
      @(negedge clk);
      if (edges == 1) chk({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk({tag, " latency"}, 32'(edges), 32'(elat));
    chk({tag, " out"}, 32'(bus.out), 32'(eo));
    chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edz));
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, " out_held"}, 32'(bus.out), 32'(eo));
  endtask

  initial begin
    logic [15:0] ra, rb, ro;
    logic        rdz;
    int          rlat;
    bit          spurious;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.x1    = 16'd0;
    bus.x2    = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset out", 32'(bus.out), 32'd0);
    chk("reset dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("8000/2", 16'h8000, 16'h0002, 16'h4000, 1'b0, 39, 0);

    // Abort mid-DIV: no done pulse, everything cleared, then a fresh operation works.
    bus.start = 1'b1;
    bus.x1    = 16'd100;
    bus.x2    = 16'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_div busy", 32'(bus.busy), 32'd0);
    chk("rst_div out", 32'(bus.out), 32'd0);
    chk("rst_div done", 32'(bus.done), 32'd0);
    chk("rst_div dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious = 1'b1;
    end
    chk("rst_div quiet", 32'(spurious), 32'd0);

    run_op("100/7 inject", 16'd100, 16'd7, 16'd14, 1'b0, 36, 3);
    run_op("3/1000", 16'd3, 16'd1000, 16'd0, 1'b0, 49, 0);
    run_op("FFFF/1", 16'hFFFF, 16'd1, 16'hFF00, 1'b0, 41, 0);
    run_op("1234/0", 16'h1234, 16'd0, 16'hFFFF, 1'b1, 1, 0);
    run_op("0/5", 16'd0, 16'd5, 16'd0, 1'b0, 1, 0);
    run_op("0/0", 16'd0, 16'd0, 16'hFFFF, 1'b1, 1, 0);
    run_op("100/7", 16'd100, 16'd7, 16'd14, 1'b0, 36, 0);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      rb = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      if (i % 11 == 5) ra = 16'd0;
      if (i % 9 == 4)  rb = 16'd0;
      if (i % 7 == 2)  ra = 16'd1;
      if (i % 8 == 3)  rb = 16'd1;
      ref_model(ra, rb, ro, rdz, rlat);
      run_op("random", ra, rb, ro, rdz, rlat, (i % 5 == 1) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/approx_div_16bit.md
Name: approx_div_16bit

Overview:
- Sequential approximate unsigned divider, the inverse operation of the team's normalise/8x8-multiply/denormalise approximate multiplier.
- Normalises both 16-bit operands by single-bit left shifts while counting leading zeros. Keeps the top byte of each, runs a 16-step restoring division, then rescales the quotient one bit per cycle.
- Sits beside the approximate multiplier under the same top-level controller and uses the same start/done handshake style.

Parameters:
- none (widths fixed: 16-bit operands, 8-bit significands, 16-bit result)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- x1  in  16  dividend, unsigned; sampled with start
- x2  in  16  divisor, unsigned; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; out valid in that cycle
- out  out  16  approximate floor(x1/x2); held until the next accepted start
- div_by_zero  out  1  set with done when x2==0; held with out

Behaviour:
- Reset (clk edge with rst=1): state IDLE; busy=0, done=0, out=0, div_by_zero=0; all internal registers and counters cleared.
- rst overrides everything, including mid-operation; no partial result becomes visible.
- IDLE:
  - start=0: hold outputs.
  - start=1 and x2==0: next state DONE; out=16'hFFFF, div_by_zero=1.
  - start=1, x2!=0, x1==0: next state DONE; out=0, div_by_zero=0.
  - Otherwise: load r1=x1, r2=x2, clear counters k1 and k2 (4-bit each), clear div_by_zero; next state NORM.
- NORM (shifting):
  - Each cycle, r1 shifts left by 1 (zero fill) and k1 increments if r1[15]==0; r2/k2 likewise and independently.
  - When r1[15] and r2[15] are both 1, go to DIV. In that cycle: a8=r1[15:8], b8=r2[15:8], rem=0, q={a8,8'h00}.
  - Lasts max(k1,k2)+1 cycles.
- DIV (16 cycles, counted by a 5-bit step counter):
  - Restoring step: {rem,q} shifts left by 1.
  - If shifted rem >= b8: rem -= b8 and q[0]=1.
  - rem is 9 bits wide.
  - Result Q = floor(a8*256/b8), always in 128..510.
  - Exit computes signed d = k2 - k1 - 8 (range -23..7, 6-bit two's complement), loads shift counter s=|d|, and sets direction = (d>=0 ? left : right).
- SCALE:
  - Each cycle with s!=0: q shifts 1 bit in the stored direction (logical, zero fill, shifted-out bits discarded) and s decrements.
  - s==0: out=q, next state DONE.
  - Lasts |d|+1 cycles.
  - A left shift never overflows: Q<=510 and d<=7.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- start while busy=1 is ignored, not queued.
- x1 and x2 may change freely after the sampling edge.
- Latency, counting from the edge that samples start to the edge that raises done:
  - Normal operands: max(k1,k2) + |d| + 19.
  - Zero-operand cases: 1.
- busy rises on the sampling edge and falls on the edge that ends DONE.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE.

Test Plan:
- x1=16'h8000, x2=16'h0002 -> k1=0, k2=14, Q=256, d=6, out=16'h4000; done 39 edges after start; div_by_zero=0.
- x1=100, x2=7 -> a8=200, b8=224, Q=228, d=-4, out=14; done after 36 edges.
- x1=3, x2=1000 -> Q=196, d=-16, out=0; done after 49 edges. x1=16'hFFFF, x2=1 -> Q=510, d=7, out=16'hFF00; done after 41 edges.
- x2=0 (any x1) -> one edge later done=1, out=16'hFFFF, div_by_zero=1. x1=0, x2=5 -> done after 1 edge, out=0, div_by_zero=0.
- Assert start again mid-NORM with different operands -> ignored; the first result completes unchanged.
- Assert rst during DIV -> next cycle IDLE with busy=0, out=0, and no done pulse. A fresh start then completes with the correct result.
- Two back-to-back starts (second asserted in the IDLE cycle right after done) -> two correct done pulses; out holds between them.
